// File: rtl/dual_issue_pkg.sv
// Shared definitions for the dual-issue pipeline: FSM encoding, register
// index width and default scoreboard latencies.
package dual_issue_pkg;

    localparam int REG_W            = 3;
    localparam int LOAD_ALU_LAT_DEF = 1;
    localparam int LOAD_BR_LAT_DEF  = 2;
    localparam int ALU_BR_LAT_DEF   = 1;

    typedef enum logic {
        RUN   = 1'b0,
        SPLIT = 1'b1
    } iss_state_e;

endpackage

// File: rtl/reg_ready_counter.sv
// Readiness counters for one architectural register: an ALU/mem-consumer
// counter and a branch-consumer counter, each reloaded with max(new, cur-1).
module reg_ready_counter #(
    parameter int CW           = 2,
    parameter int LOAD_ALU_LAT = 1,
    parameter int LOAD_BR_LAT  = 2,
    parameter int ALU_BR_LAT   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load_issue,
    input  logic alu_issue,
    output logic alu_busy,
    output logic br_busy
);

    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [CW-1:0] LD_ALU_C = CW'(LOAD_ALU_LAT);
    localparam logic [CW-1:0] LD_BR_C  = CW'(LOAD_BR_LAT);
    localparam logic [CW-1:0] ALU_BR_C = CW'(ALU_BR_LAT);

    logic [CW-1:0] alu_cnt, br_cnt;
    logic [CW-1:0] alu_nxt, br_nxt;

    // Start from the decayed value so a longer pending latency always wins.
    always_comb begin
        alu_nxt = (alu_cnt != '0) ? alu_cnt - ONE : '0;
        br_nxt  = (br_cnt  != '0) ? br_cnt  - ONE : '0;
        if (load_issue && LD_ALU_C > alu_nxt) alu_nxt = LD_ALU_C;
        if (load_issue && LD_BR_C  > br_nxt)  br_nxt  = LD_BR_C;
        if (alu_issue  && ALU_BR_C > br_nxt)  br_nxt  = ALU_BR_C;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_cnt <= '0;
            br_cnt  <= '0;
        end else begin
            alu_cnt <= alu_nxt;
            br_cnt  <= br_nxt;
        end
    end

    assign alu_busy = (alu_cnt != '0);
    assign br_busy  = (br_cnt  != '0);

endmodule

// File: rtl/issue_scoreboard_ctrl.sv
// Dual-issue controller: decides whole issue, split issue or stall for the
// IF/ID pair from a per-register readiness scoreboard.
module issue_scoreboard_ctrl
    import dual_issue_pkg::*;
#(
    parameter int NREG         = 8,
    parameter int RW           = REG_W,
    parameter int CW           = 2,
    parameter int LOAD_ALU_LAT = LOAD_ALU_LAT_DEF,
    parameter int LOAD_BR_LAT  = LOAD_BR_LAT_DEF,
    parameter int ALU_BR_LAT   = ALU_BR_LAT_DEF,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_valid,
    input  logic              i1_valid,
    input  logic [RW-1:0]     i1_rm,
    input  logic [RW-1:0]     i1_rn,
    input  logic [RW-1:0]     i1_rd,
    input  logic              i1_rm_used,
    input  logic              i1_rn_used,
    input  logic              i1_writes,
    input  logic              i1_is_branch,
    input  logic              i2_valid,
    input  logic [RW-1:0]     i2_rm,
    input  logic [RW-1:0]     i2_rn,
    input  logic [RW-1:0]     i2_rd,
    input  logic              i2_rm_used,
    input  logic              i2_rn_used,
    input  logic              i2_rd_is_src,
    input  logic              i2_writes,
    input  logic              i2_is_load,
    input  logic              flush,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              bubble1,
    output logic              bubble2,
    output logic              split_state,
    output logic [PERF_W-1:0] stall_cycles
);

    logic [NREG-1:0] alu_busy, br_busy, src1_busy;
    logic            h1, h2, dep, i1_wr;
    logic            iss1, iss2;
    iss_state_e      state, state_nxt;

    for (genvar g = 0; g < NREG; g++) begin : g_reg
        reg_ready_counter #(
            .CW          (CW),
            .LOAD_ALU_LAT(LOAD_ALU_LAT),
            .LOAD_BR_LAT (LOAD_BR_LAT),
            .ALU_BR_LAT  (ALU_BR_LAT)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .load_issue(iss2 && i2_valid && i2_is_load && (i2_rd == RW'(g))),
            .alu_issue (iss1 && i1_wr && (i1_rd == RW'(g))),
            .alu_busy  (alu_busy[g]),
            .br_busy   (br_busy[g])
        );
    end

    // Branches resolve in ID, so they wait on the longer branch latency.
    assign src1_busy = i1_is_branch ? br_busy : alu_busy;
    assign i1_wr     = i1_valid && i1_writes;

    assign h1 = i1_valid && ((i1_rm_used && src1_busy[i1_rm]) ||
                             (i1_rn_used && src1_busy[i1_rn]));
    assign h2 = i2_valid && ((i2_rm_used   && alu_busy[i2_rm]) ||
                             (i2_rn_used   && alu_busy[i2_rn]) ||
                             (i2_rd_is_src && alu_busy[i2_rd]));
    assign dep = i1_wr && i2_valid &&
                 ((i2_rm_used   && i2_rm == i1_rd) ||
                  (i2_rn_used   && i2_rn == i1_rd) ||
                  (i2_rd_is_src && i2_rd == i1_rd) ||
                  (i2_writes    && i2_rd == i1_rd));

    always_comb begin
        state_nxt   = state;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        bubble1     = 1'b1;
        bubble2     = 1'b1;
        iss1        = 1'b0;
        iss2        = 1'b0;
        if (reset) begin
            state_nxt = RUN;
        end else if (flush) begin
            pc_write    = 1'b1;
            if_id_write = 1'b1;
            state_nxt   = RUN;
        end else begin
            case (state)
                RUN: begin
                    if (!issue_valid) begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end else if (h1) begin
                        // full stall: defaults already hold everything
                    end else if (h2 || dep) begin
                        bubble1   = 1'b0;
                        iss1      = 1'b1;
                        state_nxt = SPLIT;
                    end else begin
                        bubble1     = 1'b0;
                        bubble2     = 1'b0;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        iss1        = 1'b1;
                        iss2        = 1'b1;
                    end
                end
                SPLIT: begin
                    if (!h2) begin
                        bubble2     = 1'b0;
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                        iss2        = 1'b1;
                        state_nxt   = RUN;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= RUN;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            if (!pc_write && stall_cycles != '1)
                stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

    assign split_state = (state == SPLIT);

endmodule

// File: tb/tb_issue_scoreboard_ctrl.sv
// Scoreboard bench for issue_scoreboard_ctrl: a timestamp-based readiness
// model predicts each cycle's outputs; a negedge monitor compares them.
module tb_issue_scoreboard_ctrl;

    localparam int  LD_ALU = 1;
    localparam int  LD_BR  = 2;
    localparam int  ALU_BR = 1;
    localparam int  SAT_STALLS = 65536 + 5;

    logic        clk = 1'b0;
    logic        reset, issue_valid, flush;
    logic        i1_valid, i1_rm_used, i1_rn_used, i1_writes, i1_is_branch;
    logic [2:0]  i1_rm, i1_rn, i1_rd, i2_rm, i2_rn, i2_rd;
    logic        i2_valid, i2_rm_used, i2_rn_used, i2_rd_is_src, i2_writes, i2_is_load;
    logic        pc_write, if_id_write, bubble1, bubble2, split_state;
    logic [15:0] stall_cycles;

    always #5 clk = ~clk;

    issue_scoreboard_ctrl dut (
        .clk(clk), .reset(reset), .issue_valid(issue_valid),
        .i1_valid(i1_valid), .i1_rm(i1_rm), .i1_rn(i1_rn), .i1_rd(i1_rd),
        .i1_rm_used(i1_rm_used), .i1_rn_used(i1_rn_used), .i1_writes(i1_writes),
        .i1_is_branch(i1_is_branch), .i2_valid(i2_valid), .i2_rm(i2_rm),
        .i2_rn(i2_rn), .i2_rd(i2_rd), .i2_rm_used(i2_rm_used),
        .i2_rn_used(i2_rn_used), .i2_rd_is_src(i2_rd_is_src),
        .i2_writes(i2_writes), .i2_is_load(i2_is_load), .flush(flush),
        .pc_write(pc_write), .if_id_write(if_id_write), .bubble1(bubble1),
        .bubble2(bubble2), .split_state(split_state), .stall_cycles(stall_cycles)
    );

    typedef struct {
        bit iv, fl, rst;
        bit v1, rmu1, rnu1, wr1, br1;
        int rm1, rn1, rd1;
        bit v2, rmu2, rnu2, rds2, wr2, ld2;
        int rm2, rn2, rd2;
    } stim_t;

    typedef struct {
        bit pc, ifid, b1, b2, sp;
        int unsigned st;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: each register remembers the first cycle at which an
    // ALU/mem consumer and a branch consumer may issue.
    longint      cyc = 0;
    longint      alu_rdy[8];
    longint      br_rdy[8];
    bit          m_split = 0;
    int unsigned m_stall = 0;
    longint      raw_stall = 0;
    bit          p_iss1, p_iss2, p_pc, p_nsplit, p_rst;
    stim_t       p_s;

    function automatic bit ab(int r); return cyc < alu_rdy[r]; endfunction
    function automatic bit bb(int r); return cyc < br_rdy[r];  endfunction

    function automatic stim_t blank();
        stim_t s = '{default: 0};
        s.iv = 1;
        return s;
    endfunction

    function automatic stim_t s1(stim_t s_in, int rm, int rd, bit wr, bit br);
        stim_t s = s_in;
        s.v1 = 1; s.rm1 = rm; s.rmu1 = 1; s.rd1 = rd; s.wr1 = wr; s.br1 = br;
        return s;
    endfunction

    function automatic stim_t s2(stim_t s_in, int base, int rd, bit ld);
        stim_t s = s_in;
        s.v2 = 1; s.rm2 = base; s.rmu2 = 1; s.rd2 = rd;
        s.ld2 = ld; s.wr2 = ld; s.rds2 = !ld;
        return s;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic expo(input string nm, input bit pc, input bit b1, input bit b2);
        #2;
        chk(nm, {29'd0, pc_write, bubble1, bubble2}, {29'd0, pc, b1, b2});
    endtask

    task automatic drive(input stim_t s);
        bit h1, h2, dep, b1, b2;
        exp_t e;
        reset = s.rst; issue_valid = s.iv; flush = s.fl;
        i1_valid = s.v1; i1_rm = 3'(s.rm1); i1_rn = 3'(s.rn1); i1_rd = 3'(s.rd1);
        i1_rm_used = s.rmu1; i1_rn_used = s.rnu1; i1_writes = s.wr1; i1_is_branch = s.br1;
        i2_valid = s.v2; i2_rm = 3'(s.rm2); i2_rn = 3'(s.rn2); i2_rd = 3'(s.rd2);
        i2_rm_used = s.rmu2; i2_rn_used = s.rnu2; i2_rd_is_src = s.rds2;
        i2_writes = s.wr2; i2_is_load = s.ld2;

        h1 = s.v1 && ((s.rmu1 && (s.br1 ? bb(s.rm1) : ab(s.rm1))) ||
                      (s.rnu1 && (s.br1 ? bb(s.rn1) : ab(s.rn1))));
        h2 = s.v2 && ((s.rmu2 && ab(s.rm2)) || (s.rnu2 && ab(s.rn2)) || (s.rds2 && ab(s.rd2)));
        dep = s.v1 && s.wr1 && s.v2 &&
              ((s.rmu2 && s.rm2 == s.rd1) || (s.rnu2 && s.rn2 == s.rd1) ||
               (s.rds2 && s.rd2 == s.rd1) || (s.wr2 && s.rd2 == s.rd1));

        p_iss1 = 0; p_iss2 = 0; p_pc = 0; p_nsplit = m_split; b1 = 1; b2 = 1;
        if (s.rst) p_nsplit = 0;
        else if (s.fl) begin p_pc = 1; p_nsplit = 0; end
        else if (!m_split) begin
            if (!s.iv) p_pc = 1;
            else if (h1) p_pc = 0;
            else if (h2 || dep) begin b1 = 0; p_iss1 = 1; p_nsplit = 1; end
            else begin b1 = 0; b2 = 0; p_pc = 1; p_iss1 = 1; p_iss2 = 1; end
        end else if (!h2) begin
            b2 = 0; p_pc = 1; p_iss2 = 1; p_nsplit = 0;
        end
        e.pc = p_pc; e.ifid = p_pc; e.b1 = b1; e.b2 = b2; e.sp = m_split; e.st = m_stall;
        q.push_back(e);
        p_rst = s.rst; p_s = s;
    endtask

    task automatic tick();
        if (p_rst) begin
            for (int r = 0; r < 8; r++) begin alu_rdy[r] = 0; br_rdy[r] = 0; end
            m_stall = 0; raw_stall = 0;
        end else begin
            if (p_iss1 && p_s.v1 && p_s.wr1 && br_rdy[p_s.rd1] < cyc + 1 + ALU_BR)
                br_rdy[p_s.rd1] = cyc + 1 + ALU_BR;
            if (p_iss2 && p_s.v2 && p_s.ld2) begin
                if (alu_rdy[p_s.rd2] < cyc + 1 + LD_ALU) alu_rdy[p_s.rd2] = cyc + 1 + LD_ALU;
                if (br_rdy[p_s.rd2]  < cyc + 1 + LD_BR)  br_rdy[p_s.rd2]  = cyc + 1 + LD_BR;
            end
            if (!p_pc) begin
                raw_stall++;
                if (m_stall < 65535) m_stall++;
            end
        end
        m_split = p_nsplit;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            tests++;
            if ({pc_write, if_id_write, bubble1, bubble2, split_state} !==
                    {e.pc, e.ifid, e.b1, e.b2, e.sp} || stall_cycles !== 16'(e.st)) begin
                fails++;
                $display("FAIL monitor t=%0t: got pc=%b ifid=%b b1=%b b2=%b sp=%b st=%0d expected pc=%b ifid=%b b1=%b b2=%b sp=%b st=%0d",
                         $time, pc_write, if_id_write, bubble1, bubble2, split_state, stall_cycles,
                         e.pc, e.ifid, e.b1, e.b2, e.sp, e.st);
            end
        end
    end

    initial begin
        stim_t s, pair;
        logic [15:0] st_snap;
        int iters;
        for (int r = 0; r < 8; r++) begin alu_rdy[r] = 0; br_rdy[r] = 0; end
        reset = 1; issue_valid = 0; flush = 0;
        i1_valid = 0; i1_rm = 0; i1_rn = 0; i1_rd = 0; i1_rm_used = 0; i1_rn_used = 0;
        i1_writes = 0; i1_is_branch = 0; i2_valid = 0; i2_rm = 0; i2_rn = 0; i2_rd = 0;
        i2_rm_used = 0; i2_rn_used = 0; i2_rd_is_src = 0; i2_writes = 0; i2_is_load = 0;
        repeat (2) @(posedge clk);
        #1;

        s = blank(); s.rst = 1;
        drive(s); expo("reset_out", 0, 1, 1);
        chk("reset_ifid", {31'd0, if_id_write}, 32'd0);
        chk("reset_stall", {16'd0, stall_cycles}, 32'd0);
        tick();

        // Load r3, then an ADD reading r3: one stall, then both issue.
        drive(s2(blank(), 0, 3, 1)); tick();
        drive(s1(blank(), 3, 1, 1, 0)); expo("load_use_stall", 0, 1, 1); tick();
        drive(s1(blank(), 3, 1, 1, 0)); expo("load_use_issue", 1, 0, 0);
        chk("load_use_count", {16'd0, stall_cycles}, 32'd1); tick();

        // ADD r2 paired with LDR based on r2: split issue.
        pair = s2(s1(blank(), 0, 2, 1, 0), 2, 4, 1);
        drive(pair); expo("split_first", 0, 0, 1); tick();
        chk("split_state_on", {31'd0, split_state}, 32'd1);
        drive(pair); expo("split_second", 1, 1, 0); tick();
        chk("split_state_off", {31'd0, split_state}, 32'd0);

        // ALU->branch one stall; load->branch two stalls.
        drive(s1(blank(), 0, 5, 1, 0)); tick();
        drive(s1(blank(), 5, 0, 0, 1)); expo("alu_br_stall", 0, 1, 1); tick();
        drive(s1(blank(), 5, 0, 0, 1)); expo("alu_br_issue", 1, 0, 0); tick();
        drive(s2(blank(), 0, 5, 1)); tick();
        drive(s1(blank(), 5, 0, 0, 1)); expo("ld_br_stall1", 0, 1, 1); tick();
        drive(s1(blank(), 5, 0, 0, 1)); expo("ld_br_stall2", 0, 1, 1); tick();
        drive(s1(blank(), 5, 0, 0, 1)); expo("ld_br_issue", 1, 0, 0); tick();

        // Flush while in SPLIT.
        drive(pair); tick();
        s = pair; s.fl = 1;
        drive(s); expo("flush_split", 1, 1, 1);
        st_snap = stall_cycles; tick();
        chk("flush_state", {31'd0, split_state}, 32'd0);
        chk("flush_stall_hold", {16'd0, stall_cycles}, {16'd0, st_snap});

        // Reset in the middle of a load-use stall.
        drive(s2(blank(), 0, 3, 1)); tick();
        s = s1(blank(), 3, 1, 1, 0); s.rst = 1;
        drive(s); expo("reset_mid_stall", 0, 1, 1); tick();
        drive(s1(blank(), 3, 1, 1, 0)); expo("post_reset_issue", 1, 0, 0); tick();

        // Randomized traffic over a small register set to provoke hazards.
        for (int n = 0; n < 1500; n++) begin
            s = '{default: 0};
            s.iv = ($urandom_range(0, 7) != 0);
            s.fl = ($urandom_range(0, 15) == 0);
            s.rst = ($urandom_range(0, 63) == 0);
            s.v1 = ($urandom_range(0, 3) != 0);
            s.rm1 = $urandom_range(0, 3); s.rn1 = $urandom_range(0, 3); s.rd1 = $urandom_range(0, 3);
            s.rmu1 = $urandom_range(0, 1); s.rnu1 = $urandom_range(0, 1);
            s.wr1 = $urandom_range(0, 1); s.br1 = ($urandom_range(0, 3) == 0);
            s.v2 = ($urandom_range(0, 3) != 0);
            s.rm2 = $urandom_range(0, 3); s.rn2 = $urandom_range(0, 3); s.rd2 = $urandom_range(0, 3);
            s.rmu2 = $urandom_range(0, 1); s.rnu2 = $urandom_range(0, 1);
            s.rds2 = $urandom_range(0, 1); s.wr2 = $urandom_range(0, 1);
            s.ld2 = $urandom_range(0, 1);
            drive(s); tick();
        end

        // Saturation: branch(r3, writes r7) + load r3 based on r7 stalls 3 of 4 cycles.
        s = blank(); s.rst = 1; drive(s); tick();
        pair = s2(s1(blank(), 3, 7, 1, 1), 3, 3, 1);
        pair.rn2 = 7; pair.rnu2 = 1;
        iters = 0;
        while (raw_stall < SAT_STALLS && iters < 95000) begin
            drive(pair); tick();
            iters++;
        end
        chk("sat_reached", {31'd0, raw_stall >= SAT_STALLS}, 32'd1);
        chk("sat_value", {16'd0, stall_cycles}, 32'h0000_FFFF);
        drive(pair); tick();
        chk("sat_hold", {16'd0, stall_cycles}, 32'h0000_FFFF);

        @(negedge clk);
        #1;
        chk("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
